circular_dma_arbiter: RTL



---
 rtl/circular_dma_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/circular_dma_arbiter.sv
// -----------------------------------------------------------------------------
// circular_dma_arbiter
//
// Packet-granular round-robin arbiter sharing the single stream input of the
// circular DMA among C_NUM_INPUTS AXI-Stream producers. A packet, once
// granted, runs to its tlast beat before any other input can be granted, so
// beats of different packets are never interleaved. The block also owns the
// stream-side shutdown handshake. On a shutdown request it finishes the packet
// in flight, stops granting and acknowledges while halted.
//
// Ports:
//   clk            : clock, all logic on the rising edge
//   rst            : asynchronous, active-high reset
//   shutdown_req   : level request to quiesce the stream
//   shutdown_ack   : registered, high while halted
//   s_axis_tdata   : producer data, input i at bits [i*W +: W]
//   s_axis_tlast   : per-input packet end
//   s_axis_tvalid  : per-input valid
//   s_axis_tready  : per-input ready (only the granted input may see ready)
//   m_axis_tdata   : to DMA s_axis_s2mm_tdata (zero-latency pass-through)
//   m_axis_tlast   : to DMA
//   m_axis_tvalid  : to DMA
//   m_axis_tready  : from DMA
//   m_axis_tid     : index of the granted input, meaningful while tvalid=1
// -----------------------------------------------------------------------------
module circular_dma_arbiter #(
   parameter int C_NUM_INPUTS = 4,
   parameter int C_AXIS_WIDTH = 64,
   parameter int C_ID_WIDTH   = $clog2(C_NUM_INPUTS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 shutdown_req,
   output logic                                 shutdown_ack,
   input  logic [C_NUM_INPUTS*C_AXIS_WIDTH-1:0] s_axis_tdata,
   input  logic [C_NUM_INPUTS-1:0]              s_axis_tlast,
   input  logic [C_NUM_INPUTS-1:0]              s_axis_tvalid,
   output logic [C_NUM_INPUTS-1:0]              s_axis_tready,
   output logic [C_AXIS_WIDTH-1:0]              m_axis_tdata,
   output logic                                 m_axis_tlast,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [C_ID_WIDTH-1:0]                m_axis_tid
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PASS   = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // Index of the last input so that input 0 has first priority after reset.
   localparam logic [C_ID_WIDTH-1:0] LAST_INDEX = C_ID_WIDTH'(C_NUM_INPUTS - 1);

   logic [1:0]              state_r;
   logic [1:0]              state_next_s;
   logic [C_ID_WIDTH-1:0]   grant_r;
   logic [C_ID_WIDTH-1:0]   grant_next_s;
   logic [C_ID_WIDTH-1:0]   last_grant_r;
   logic [C_ID_WIDTH-1:0]   last_grant_next_s;
   logic                    shutdown_ack_r;

   logic                    in_pass_s;
   logic [C_AXIS_WIDTH-1:0] sel_data_s;
   logic                    sel_valid_s;
   logic                    sel_last_s;
   logic                    last_beat_done_s;
   logic [C_ID_WIDTH-1:0]   rr_pick_s;
   logic                    rr_found_s;

   // Zero-latency datapath: the granted input's beat goes straight through.
   assign in_pass_s   = (state_r == ST_PASS);
   assign sel_data_s  = s_axis_tdata[int'(grant_r)*C_AXIS_WIDTH +: C_AXIS_WIDTH];
   assign sel_valid_s = s_axis_tvalid[grant_r];
   assign sel_last_s  = s_axis_tlast[grant_r];

   assign last_beat_done_s = in_pass_s & sel_valid_s & sel_last_s & m_axis_tready;

   assign m_axis_tdata  = sel_data_s;
   assign m_axis_tvalid = in_pass_s & sel_valid_s;
   assign m_axis_tlast  = in_pass_s & sel_last_s;
   assign m_axis_tid    = grant_r;
   assign shutdown_ack  = shutdown_ack_r;

   // Ready depends only on registered state, never on any producer's tvalid.
   assign s_axis_tready = in_pass_s ? (C_NUM_INPUTS'(m_axis_tready) << grant_r)
                                    : {C_NUM_INPUTS{1'b0}};

   // Round-robin pick: first valid input scanning upward from last_grant+1.
   always_comb begin
      int  idx;
      logic hit;
      idx        = 0;
      hit        = 1'b0;
      rr_pick_s  = '0;
      rr_found_s = 1'b0;
      for (int k = 1; k <= C_NUM_INPUTS; k++) begin
         idx        = (int'(last_grant_r) + k) % C_NUM_INPUTS;
         hit        = s_axis_tvalid[idx] & ~rr_found_s;
         rr_pick_s  = hit ? C_ID_WIDTH'(idx) : rr_pick_s;
         rr_found_s = rr_found_s | hit;
      end
   end

   // Next-state logic for the IDLE / PASS / HALTED controller.
   always_comb begin
      state_next_s      = state_r;
      grant_next_s      = grant_r;
      last_grant_next_s = last_grant_r;
      case (state_r)
         ST_IDLE: begin
            // Shutdown outranks any pending request.
            if (shutdown_req) begin
               state_next_s = ST_HALTED;
            end else if (rr_found_s) begin
               state_next_s = ST_PASS;
               grant_next_s = rr_pick_s;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_PASS: begin
            // Only a completed tlast handshake ends the packet; a producer
            // dropping tvalid mid-packet simply stalls here.
            if (last_beat_done_s) begin
               last_grant_next_s = grant_r;
               state_next_s      = shutdown_req ? ST_HALTED : ST_IDLE;
            end else begin
               state_next_s = ST_PASS;
            end
         end
         ST_HALTED: begin
            if (shutdown_req) begin
               state_next_s = ST_HALTED;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, grant bookkeeping and the registered shutdown acknowledge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         grant_r        <= '0;
         last_grant_r   <= LAST_INDEX;
         shutdown_ack_r <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         grant_r        <= grant_next_s;
         last_grant_r   <= last_grant_next_s;
         // Ack rises on the edge entering HALTED and clears on the edge leaving it.
         shutdown_ack_r <= (state_next_s == ST_HALTED);
      end
   end

endmodule
